// File: rtl/collect_2x1_src_tag_seq.sv
// 2-to-1 collection switch: two input FIFOs, round-robin merge into a registered output,
// and a source bit prepended to each word's route tag (1 = high input, 0 = low input).
module collect_2x1_src_tag_seq #(
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned SOURCE_TAG_WIDTH = 1,
   parameter int unsigned FIFO_DEPTH       = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_en,
   input  logic [1:0]                    i_valid,
   input  logic [2*DATA_WIDTH-1:0]       i_data_bus,
   input  logic [2*SOURCE_TAG_WIDTH-1:0] i_cmd,
   output logic [1:0]                    o_ready,
   output logic                          o_valid,
   output logic [DATA_WIDTH-1:0]         o_data_bus,
   output logic [SOURCE_TAG_WIDTH:0]     o_cmd,
   input  logic                          i_ready
);

   localparam int unsigned EW = DATA_WIDTH + SOURCE_TAG_WIDTH;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   logic [1:0]    not_empty;
   logic [1:0]    push;
   logic [1:0]    pop;
   logic [EW-1:0] head [2];

   for (genvar k = 0; k < 2; k++) begin : g_fifo
      logic [EW-1:0] mem_q [FIFO_DEPTH];
      logic [PW-1:0] wr_ptr_q;
      logic [PW-1:0] rd_ptr_q;
      logic [CW-1:0] count_q;

      // Ready is gated by rst so nothing is offered upstream while reset is held.
      assign o_ready[k]   = rst & i_en & (count_q < FULL_COUNT);
      assign push[k]      = i_valid[k] & o_ready[k];
      assign not_empty[k] = (count_q != '0);
      assign head[k]      = mem_q[rd_ptr_q];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push[k]) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop[k])  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push[k] && !pop[k]) begin
               count_q <= count_q + 1'b1;
            end else if (!push[k] && pop[k]) begin
               count_q <= count_q - 1'b1;
            end
         end
      end

      // Storage needs no reset: entries are only read once counted in.
      always_ff @(posedge clk) begin
         if (push[k]) begin
            mem_q[wr_ptr_q] <= {i_data_bus[k*DATA_WIDTH +: DATA_WIDTH],
                                i_cmd[k*SOURCE_TAG_WIDTH +: SOURCE_TAG_WIDTH]};
         end
      end
   end

   logic          prio_high_q;
   logic          grant_high;
   logic          load;
   logic [EW-1:0] sel;

   assign load       = i_en & (~o_valid | i_ready) & (|not_empty);
   // prio_high_q set means the high input wins the next contention.
   assign grant_high = not_empty[1] & (~not_empty[0] | prio_high_q);
   assign pop        = {load & grant_high, load & ~grant_high};
   assign sel        = grant_high ? head[1] : head[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_valid     <= 1'b0;
         o_data_bus  <= '0;
         o_cmd       <= '0;
         prio_high_q <= 1'b1;
      end else if (load) begin
         o_valid     <= 1'b1;
         o_data_bus  <= sel[EW-1 -: DATA_WIDTH];
         o_cmd       <= {grant_high, sel[SOURCE_TAG_WIDTH-1:0]};
         prio_high_q <= ~grant_high;
      end else if (o_valid && i_ready) begin
         o_valid    <= 1'b0;
         o_data_bus <= '0;
         o_cmd      <= '0;
      end
   end

endmodule

// File: tb/tb_collect_2x1_src_tag_seq.sv
// Bench for collect_2x1_src_tag_seq: directed scenarios plus random traffic, all compared
// cycle by cycle against a queue-based reference model.
module tb_collect_2x1_src_tag_seq;

   localparam int unsigned DW    = 32;
   localparam int unsigned TW    = 1;
   localparam int unsigned DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_en = 1'b0;
   logic [1:0]    i_valid = '0;
   logic [2*DW-1:0] i_data_bus = '0;
   logic [2*TW-1:0] i_cmd = '0;
   logic [1:0]    o_ready;
   logic          o_valid;
   logic [DW-1:0] o_data_bus;
   logic [TW:0]   o_cmd;
   logic          i_ready = 1'b0;

   collect_2x1_src_tag_seq #(
      .DATA_WIDTH      (DW),
      .SOURCE_TAG_WIDTH(TW),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_en      (i_en),
      .i_valid   (i_valid),
      .i_data_bus(i_data_bus),
      .i_cmd     (i_cmd),
      .o_ready   (o_ready),
      .o_valid   (o_valid),
      .o_data_bus(o_data_bus),
      .o_cmd     (o_cmd),
      .i_ready   (i_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: per-input queues of {data, tag} and the output register.
   logic [DW+TW-1:0] qh[$];
   logic [DW+TW-1:0] ql[$];
   logic             m_valid;
   logic [DW-1:0]    m_data;
   logic [TW:0]      m_cmd;
   logic             m_last_high;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      qh.delete();
      ql.delete();
      m_valid     = 1'b0;
      m_data      = '0;
      m_cmd       = '0;
      m_last_high = 1'b0;
   endtask

   // One clock cycle: drive inputs, compare DUT against the model, then advance the model.
   task automatic cycle(input logic en, input logic [1:0] v, input logic rdy,
                        input logic [DW-1:0] dh, input logic [DW-1:0] dl,
                        input logic th, input logic tl);
      logic             rh, rl, ld, pick;
      logic [DW+TW-1:0] w;
      @(negedge clk);
      i_en       = en;
      i_valid    = v;
      i_ready    = rdy;
      i_data_bus = {dh, dl};
      i_cmd      = {th, tl};
      #1;
      rh = en && (qh.size() < DEPTH);
      rl = en && (ql.size() < DEPTH);
      check_eq("o_ready", 64'(o_ready), 64'({rh, rl}));
      check_eq("o_valid", 64'(o_valid), 64'(m_valid));
      check_eq("o_data_bus", 64'(o_data_bus), 64'(m_data));
      check_eq("o_cmd", 64'(o_cmd), 64'(m_cmd));
      ld = en && (!m_valid || rdy) && (qh.size() > 0 || ql.size() > 0);
      if (ld) begin
         pick = (qh.size() > 0) && ((ql.size() == 0) || !m_last_high);
         w    = pick ? qh.pop_front() : ql.pop_front();
         m_valid     = 1'b1;
         m_data      = w[DW+TW-1:TW];
         m_cmd       = {pick, w[TW-1:0]};
         m_last_high = pick;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_cmd   = '0;
      end
      if (v[1] && rh) qh.push_back({dh, th});
      if (v[0] && rl) ql.push_back({dl, tl});
   endtask

   task automatic idle(input logic en, input logic rdy, input int n);
      for (int i = 0; i < n; i++) cycle(en, 2'b00, rdy, '0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_o_ready", 64'(o_ready), 64'(0));
      check_eq("reset_o_valid", 64'(o_valid), 64'(0));
      check_eq("reset_o_data", 64'(o_data_bus), 64'(0));
      @(negedge clk);
      rst = 1'b1;

      // Single word on the low input.
      cycle(1'b1, 2'b01, 1'b1, '0, 32'hA5, 1'b0, 1'b1);
      cycle(1'b1, 2'b00, 1'b1, '0, '0, 1'b0, 1'b0);
      cycle(1'b1, 2'b00, 1'b1, '0, '0, 1'b0, 1'b0);
      check_eq("t1_valid", 64'(o_valid), 64'(1));
      check_eq("t1_data", 64'(o_data_bus), 64'h0A5);
      check_eq("t1_cmd", 64'(o_cmd), 64'(2'b01));
      idle(1'b1, 1'b1, 3);

      // Both inputs streaming, downstream always ready.
      for (int i = 0; i < 20; i++)
         cycle(1'b1, 2'b11, 1'b1, 32'h100 + i, 32'h200 + i, 1'(i), 1'(i + 1));
      idle(1'b1, 1'b1, 6);

      // Backpressure, then release with a push attempted on the release cycle.
      for (int i = 0; i < 6; i++)
         cycle(1'b1, 2'b11, 1'b0, 32'h300 + i, 32'h400 + i, 1'b1, 1'b0);
      cycle(1'b1, 2'b11, 1'b1, 32'h3F0, 32'h4F0, 1'b0, 1'b1);
      cycle(1'b1, 2'b11, 1'b1, 32'h3F1, 32'h4F1, 1'b1, 1'b1);
      idle(1'b1, 1'b1, 8);

      // Fill, then drop enable with a word held in the output register.
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 2'b11, 1'b0, 32'h500 + i, 32'h600 + i, 1'b0, 1'b0);
      idle(1'b0, 1'b0, 2);
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 2'b11, 1'b1, 32'h700 + i, 32'h800 + i, 1'b1, 1'b1);
      idle(1'b1, 1'b1, 8);

      // Asynchronous reset in the middle of a burst.
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 2'b11, 1'(i % 2), 32'h900 + i, 32'hA00 + i, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      rst     = 1'b0;
      i_en    = 1'b0;
      i_valid = 2'b00;
      #1;
      check_eq("arst_o_valid", 64'(o_valid), 64'(0));
      check_eq("arst_o_data", 64'(o_data_bus), 64'(0));
      check_eq("arst_o_cmd", 64'(o_cmd), 64'(0));
      check_eq("arst_o_ready", 64'(o_ready), 64'(0));
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      cycle(1'b1, 2'b11, 1'b1, 32'hB00, 32'hC00, 1'b0, 1'b0);
      cycle(1'b1, 2'b00, 1'b1, '0, '0, 1'b0, 1'b0);
      cycle(1'b1, 2'b00, 1'b1, '0, '0, 1'b0, 1'b0);
      check_eq("post_rst_grant_high", 64'(o_cmd[TW]), 64'(1));
      check_eq("post_rst_data", 64'(o_data_bus), 64'hB00);
      idle(1'b1, 1'b1, 4);

      // Random traffic.
      for (int i = 0; i < 600; i++)
         cycle(1'($urandom_range(0, 9) != 0), 2'($urandom), 1'($urandom_range(0, 3) != 0),
               $urandom, $urandom, 1'($urandom), 1'($urandom));
      idle(1'b1, 1'b1, 10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/collect_2x1_src_tag_seq.md
Name: collect_2x1_src_tag_seq

Overview:
Sequential 2-to-1 collection switch, the return-path counterpart of the 1x2 destination-tag distribute switch. It merges two upstream streams into one downstream stream using round-robin arbitration. It buffers each input in a small FIFO and registers the output. It rebuilds the route tag by prepending a source bit (1 = high input, 0 = low input) to each word's incoming tag, inverting the distribute switch's consume-MSB rule.

Parameters:
DATA_WIDTH, 32, width of one data word
SOURCE_TAG_WIDTH, 1, width of the tag carried on each input; the output tag is SOURCE_TAG_WIDTH+1 wide
FIFO_DEPTH, 2, entries per input FIFO; power of 2, at least 2

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-low
i_en  input  1  switch enable
i_valid  input  2  per-input valid; bit 1 = high input, bit 0 = low input
i_data_bus  input  2*DATA_WIDTH  {i_data_high, i_data_low}
i_cmd  input  2*SOURCE_TAG_WIDTH  {i_cmd_high, i_cmd_low}
o_ready  output  2  per-input ready to upstream
o_valid  output  1  output word valid
o_data_bus  output  DATA_WIDTH  merged output data
o_cmd  output  SOURCE_TAG_WIDTH+1  {source_bit, stored input tag}
i_ready  input  1  downstream ready

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-low.
- Reset (rst=0, async):
  - both FIFOs empty, counts 0;
  - o_valid=0, o_data_bus=0, o_cmd=0;
  - o_ready=2'b00 while rst is asserted;
  - round-robin pointer set so the high input wins the first contention.
- Input handshake, per input k:
  - o_ready[k] = i_en & (count_k < FIFO_DEPTH), computed from the pre-pop count.
  - A full FIFO deasserts ready even if it pops in the same cycle.
  - Push occurs at the edge where i_valid[k] & o_ready[k]; the stored entry is {i_data_k, i_cmd_k}.
  - When o_ready[k]=0, i_valid[k] is ignored and the word is not stored.
- Output stage: a single register.
  - Load condition: load = i_en & (~o_valid | i_ready) & (fifo_high non-empty | fifo_low non-empty).
  - Transfer completes at any edge with o_valid & i_ready.
  - When o_valid=1 and i_ready=0, o_valid, o_data_bus and o_cmd hold stable; no arbitration occurs.
  - If no load occurs and the register drains, o_valid falls to 0 and o_data_bus/o_cmd go to 0.
- Arbitration:
  - If only one FIFO is non-empty, grant it.
  - If both are non-empty, grant the input not granted last time, then update the pointer.
  - The pointer updates only on a load.
- Tag rule: o_cmd = {1'b1, tag} when the high FIFO is granted; o_cmd = {1'b0, tag} when the low FIFO is granted.
- Latency: a word pushed at edge N can be loaded at edge N+1 at the earliest (o_valid in the following cycle), i.e. 2 cycles minimum. No bypass path.
- Throughput: 1 word/cycle sustained when i_ready=1. Each FIFO performs at most one pop and one push per cycle.
- Simultaneous push and pop on one FIFO: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- i_en=0:
  - o_ready=2'b00 and no new loads;
  - a word already in the output register still completes on i_ready;
  - FIFO contents are retained.
- Reset mid-operation: all buffered and in-flight words are discarded with no partial output. Operation resumes from the reset state after rst deasserts.
- Ordering: per-input order preserved. No word is dropped or duplicated.

Test Plan:
1. Reset, i_en=1, i_ready=1; only the low input sends D=0xA5 with tag 1'b1 -> o_valid is high 2 cycles later with o_data_bus=0xA5, o_cmd=2'b01; o_ready stays 2'b11.
2. Both inputs send continuously (high 0x100.., low 0x200..) with i_ready=1 -> output alternates high, low, high, low, starting with high; o_cmd MSB toggles 1,0,1,0; one word per cycle after fill.
3. i_ready=0 for 6 cycles while both inputs keep sending -> o_valid/o_data_bus held constant; each o_ready drops to 0 after FIFO_DEPTH accepted words (plus one feeding the output register); on release, all words drain in order with none lost.
4. A FIFO is full and i_ready is reasserted, with i_valid=1 on the same cycle -> o_ready is 0 that cycle and the push is refused; next cycle o_ready=1 and the push is accepted.
5. i_en dropped with a word in the output register and both FIFOs non-empty -> register word completes on i_ready; no new o_valid; o_ready=2'b00; contents emerge intact after i_en=1.
6. rst asserted asynchronously mid-burst -> outputs 0 immediately; after release, the first contention grants the high input and no stale word appears.
